// File: rtl/vsd_pkg.sv
// Shared types and sizes for the virtual-SD sector controller.
// No logic: state encoding and buffer geometry only.
// Consumers: vsd_sector_buf, vsd_sector_ctrl.
package vsd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        FIN  = 2'd3
    } vsd_state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int BUF_AW       = $clog2(SECTOR_BYTES);

endpackage

// File: rtl/vsd_sector_buf.sv
// True dual-port 512x8 sector RAM; port A = HPS side, port B = CPU side.
// Latency: 1 cycle, registered read data, read-before-write on each port and across ports.
// Backpressure: none; write enables are already gated by the controller.
module vsd_sector_buf
    import vsd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BUF_AW-1:0] a_addr,
    input  logic [7:0]        a_din,
    input  logic              a_we,
    output logic [7:0]        a_dout,
    input  logic [BUF_AW-1:0] b_addr,
    input  logic [7:0]        b_din,
    input  logic              b_we,
    output logic [7:0]        b_dout
);

    logic [7:0] mem [SECTOR_BYTES];

    // Array contents are deliberately not reset so the block maps onto block RAM.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_din;
        if (b_we) mem[b_addr] <= b_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout <= 8'h00;
            b_dout <= 8'h00;
        end else begin
            a_dout <= mem[a_addr];
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/vsd_sector_ctrl.sv
// Single-sector transfer sequencer between the CPU SD interface and hps_io virtual SD; owns the sector buffer.
// Latency: request -> sd_rd/sd_wr next cycle; buffer reads 1 cycle; optional REQ timeout under VSD_TIMEOUT_EN.
// Backpressure: requests while busy are dropped, CPU buffer writes while busy are dropped, REQ waits for sd_ack.
module vsd_sector_ctrl
    import vsd_pkg::*;
#(
    parameter int LBA_W       = 32,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk_sys,
    input  logic              RESET_N,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [LBA_W-1:0]  req_lba,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [BUF_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_we,
    output logic [7:0]        cpu_dout,
    output logic [LBA_W-1:0]  sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [BUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din
);

    vsd_state_t state_q, state_d;
    logic       dir_rd_q;
    logic       to_hit;
    logic       hps_we;
    logic       cpu_we_ok;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            sd_lba   <= '0;
            dir_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (req_rd || req_wr)) begin
                sd_lba   <= req_lba;
                dir_rd_q <= req_rd;
            end
        end
    end

`ifdef VSD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             in_req_q;
    logic             abort_q;

    // The first REQ cycle only clears the counter; counting starts on the second.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q    <= '0;
            in_req_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            in_req_q <= (state_q == REQ);
            cnt_q    <= (state_q == REQ && in_req_q) ? cnt_q + 1'b1 : '0;
            if (state_q == REQ && to_hit)
                abort_q <= 1'b1;
            else if (state_q == IDLE)
                abort_q <= 1'b0;
        end
    end

    assign to_hit = !sd_ack && in_req_q && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign err    = (state_q == FIN) && abort_q;
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        sd_rd     = 1'b0;
        sd_wr     = 1'b0;
        hps_we    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (req_rd || req_wr) state_d = REQ;
            end
            REQ: begin
                sd_rd = dir_rd_q;
                sd_wr = !dir_rd_q;
                if (sd_ack)      state_d = XFER;
                else if (to_hit) state_d = FIN;
            end
            XFER: begin
                // HPS may only fill the buffer when it is delivering a sector to us.
                hps_we = sd_ack && sd_buff_wr && dir_rd_q;
                if (!sd_ack) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cpu_we_ok = cpu_we && !busy;
    end

    vsd_sector_buf u_buf (
        .clk    (clk_sys),
        .rst_n  (RESET_N),
        .a_addr (sd_buff_addr),
        .a_din  (sd_buff_dout),
        .a_we   (hps_we),
        .a_dout (sd_buff_din),
        .b_addr (cpu_addr),
        .b_din  (cpu_din),
        .b_we   (cpu_we_ok),
        .b_dout (cpu_dout)
    );

endmodule

// File: tb/tb_vsd_sector_ctrl.sv
// Directed bench for vsd_sector_ctrl: CPU buffer vector table plus read/write/priority/protect/reset sequences.
// Timeout sequence is built only when VSD_TIMEOUT_EN is defined.
module tb_vsd_sector_ctrl;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic        req_rd, req_wr;
    logic [31:0] req_lba;
    logic        busy, done, err;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    vsd_sector_ctrl #(.LBA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk_sys      (clk_sys),
        .RESET_N      (RESET_N),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_we       (cpu_we),
        .cpu_dout     (cpu_dout),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    always @(posedge clk_sys) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic       we;
        logic [8:0] addr;
        logic [7:0] din;
        logic       chk;
        logic [7:0] exp;
    } cpu_vec_t;

    cpu_vec_t tbl [8];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap;

        RESET_N = 1'b0;
        req_rd = 0; req_wr = 0; req_lba = '0;
        cpu_addr = '0; cpu_din = '0; cpu_we = 0;
        sd_ack = 0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_sd_buff_din", sd_buff_din, 0);
        RESET_N = 1'b1;
        tick();

        // CPU port vectors while idle (read-before-write on entry 4)
        tbl[0] = '{1'b1, 9'h010, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 9'h1FF, 8'h3C, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 9'h010, 8'h00, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 9'h1FF, 8'h00, 1'b1, 8'h3C};
        tbl[4] = '{1'b1, 9'h010, 8'h5A, 1'b1, 8'hA5};
        tbl[5] = '{1'b0, 9'h010, 8'h00, 1'b1, 8'h5A};
        tbl[6] = '{1'b1, 9'h000, 8'h11, 1'b0, 8'h00};
        tbl[7] = '{1'b0, 9'h000, 8'h00, 1'b1, 8'h11};
        for (int i = 0; i < 8; i++) begin
            cpu_we = tbl[i].we; cpu_addr = tbl[i].addr; cpu_din = tbl[i].din;
            tick();
            if (tbl[i].chk) chk($sformatf("cpu_vec%0d", i), cpu_dout, tbl[i].exp);
        end
        cpu_we = 0;

        // Read transfer, with an ignored req_wr during XFER
        snap = done_cnt;
        req_rd = 1; req_lba = 32'h0000_0123;
        tick();
        req_rd = 0;
        chk("rd_sd_lba", sd_lba, 32'h123);
        chk("rd_sd_rd", sd_rd, 1);
        chk("rd_sd_wr", sd_wr, 0);
        chk("rd_busy", busy, 1);
        sd_ack = 1;
        tick();
        chk("rd_sd_rd_cleared", sd_rd, 0);
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a9;
            a9 = i[8:0];
            sd_buff_wr = 1; sd_buff_addr = a9; sd_buff_dout = a9[7:0];
            req_wr = (i == 100);
            tick();
        end
        req_wr = 0; sd_buff_wr = 0; sd_ack = 0;
        tick();
        chk("rd_done", done, 1);
        chk("rd_err", err, 0);
        chk("rd_busy_fin", busy, 1);
        tick();
        chk("rd_idle_busy", busy, 0);
        chk("rd_idle_done", done, 0);
        tick(); tick();
        chk("ignored_req_busy", busy, 0);
        chk("ignored_req_sd_wr", sd_wr, 0);
        chk("rd_one_done", done_cnt - snap, 1);
        cpu_addr = 9'h1FF; tick();
        chk("rd_buf_1ff", cpu_dout, 8'hFF);
        cpu_addr = 9'h0AB; tick();
        chk("rd_buf_0ab", cpu_dout, 8'hAB);

        // Write transfer with CPU write protection
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a9;
            a9 = i[8:0];
            cpu_we = 1; cpu_addr = a9; cpu_din = ~a9[7:0];
            tick();
        end
        cpu_we = 0;
        req_wr = 1; req_lba = 32'd7;
        tick();
        req_wr = 0;
        chk("wr_sd_wr", sd_wr, 1);
        chk("wr_sd_rd", sd_rd, 0);
        chk("wr_sd_lba", sd_lba, 7);
        cpu_we = 1; cpu_addr = 9'h000; cpu_din = 8'h55;
        tick();
        cpu_we = 0;
        sd_ack = 1;
        tick();
        sd_buff_addr = 9'h005;
        tick();
        chk("wr_din_005", sd_buff_din, 8'hFA);
        sd_buff_wr = 1; sd_buff_dout = 8'h00;
        tick();
        sd_buff_wr = 0;
        tick();
        chk("wr_hps_write_ignored", sd_buff_din, 8'hFA);
        sd_buff_addr = 9'h1FF;
        tick();
        chk("wr_din_1ff", sd_buff_din, 8'h00);
        sd_ack = 0;
        tick();
        chk("wr_done", done, 1);
        chk("wr_err", err, 0);
        tick();
        chk("wr_idle", busy, 0);
        cpu_addr = 9'h000; tick();
        chk("protect_buf0", cpu_dout, 8'hFF);
        cpu_we = 1; cpu_din = 8'h55; tick();
        cpu_we = 0; tick();
        chk("idle_write_buf0", cpu_dout, 8'h55);

        // Priority, then a request held across FIN into the first IDLE cycle
        req_rd = 1; req_wr = 1; req_lba = 32'h42;
        tick();
        req_rd = 0; req_wr = 0;
        chk("prio_sd_rd", sd_rd, 1);
        chk("prio_sd_wr", sd_wr, 0);
        sd_ack = 1; tick();
        sd_ack = 0; tick();
        chk("prio_done", done, 1);
        req_wr = 1; req_lba = 32'h99;
        tick();
        chk("b2b_idle", busy, 0);
        tick();
        req_wr = 0;
        chk("b2b_sd_wr", sd_wr, 1);
        chk("b2b_sd_lba", sd_lba, 32'h99);
        sd_ack = 1; tick();
        sd_ack = 0; tick();
        chk("b2b_done", done, 1);
        tick();

        // Asynchronous reset during XFER
        req_rd = 1; req_lba = 32'h55;
        tick();
        req_rd = 0; sd_ack = 1;
        tick();
        chk("xrst_pre_busy", busy, 1);
        snap = done_cnt;
        RESET_N = 1'b0;
        #1;
        chk("xrst_busy", busy, 0);
        chk("xrst_sd_rd", sd_rd, 0);
        chk("xrst_sd_wr", sd_wr, 0);
        chk("xrst_sd_lba", sd_lba, 0);
        sd_ack = 0;
        tick(); tick();
        RESET_N = 1'b1;
        tick(); tick();
        chk("xrst_no_done", done_cnt - snap, 0);
        req_wr = 1; req_lba = 32'd9;
        tick();
        req_wr = 0;
        chk("xrst_next_sd_wr", sd_wr, 1);
        chk("xrst_next_lba", sd_lba, 9);
        sd_ack = 1; tick();
        sd_ack = 0; tick();
        chk("xrst_next_done", done, 1);
        tick();
        chk("xrst_next_idle", busy, 0);

`ifdef VSD_TIMEOUT_EN
        req_rd = 1; req_lba = 32'h77;
        tick();
        req_rd = 0;
        chk("to_sd_rd", sd_rd, 1);
        for (int k = 0; k < 16; k++) tick();
        chk("to_not_yet", done, 0);
        chk("to_sd_rd_held", sd_rd, 1);
        tick();
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_sd_rd_drop", sd_rd, 0);
        tick();
        chk("to_idle", busy, 0);
        chk("to_err_clear", err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
